mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit in the execute stage, directly downstream of the register file. It takes the rs/rt read values (`sData`/`tData`) and computes signed or unsigned 32×32 products and quotients into private HI/LO registers over several cycles. The pipeline stalls on `busy` and later moves HI/LO back to the register file write port through MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be even and ≥ 4.

- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  operation request, sampled each rising edge
- `op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
  - 110 and 111 are reserved
- `sData`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- `tData`  in  WIDTH  rt operand: multiplier or divisor
- `busy`  out  1  iterative operation in progress; new `start` ignored
- `done`  out  1  one-cycle pulse, high in the cycle new HI/LO from a MULT/DIV are first visible
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- **States:**
  - IDLE
  - ITER: WIDTH iterations, one bit per cycle
  - FIX: sign correction and HI/LO commit
- **Accepting a request:** `start` is accepted only in IDLE, i.e. while `busy`=0.
  - `start` while `busy`=1 is dropped silently. The requester must hold it until it is accepted.
  - Reserved `op` codes are ignored: no state change, no `done`.
- **MTHI/MTLO:** `hi`/`lo` ← `sData` at the accepting edge. The FSM stays in IDLE, `busy` stays 0, and no `done` pulse is issued.
- **MULT/MULTU (shift-add):**
  - Operand magnitudes are latched at the accepting edge. MULTU treats operands as unsigned.
  - FIX negates the 2·WIDTH product when the operand signs differ (signed op only).
  - Result: {`hi`,`lo`} = full 2·WIDTH product.
- **DIV/DIVU (restoring, on magnitudes):**
  - `lo` = quotient, `hi` = remainder.
  - Signed: quotient is truncated toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (`tData`=0, detected at accept): runs full latency. Result `lo` = all ones, `hi` = `sData` unchanged.
  - Signed overflow (most-negative / −1): `lo` = most-negative value, `hi` = 0.
- **Operand stability:** operands are latched at accept. Changes to `sData`/`tData` afterwards have no effect.
- **Reset:** `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM → IDLE.
  - Reset mid-operation aborts it with no `done` and no HI/LO update.
  - Reset wins over a simultaneous `start`.

## Timing
- **Multiply/divide sequence:** `start` is accepted at edge E0.
  - `busy`=1 from after E0 through the cycle ending at E(WIDTH+1).
  - `hi`/`lo` are written at E(WIDTH+1).
  - `done`=1 and `busy`=0 during the cycle after E(WIDTH+1).
- **Latency:** WIDTH+1 cycles from accept to result (33 for WIDTH=32).
- **Back-to-back:** a new `start` is accepted in the `done` cycle, so there is no dead cycle.
- **MTHI/MTLO:** result is visible the cycle after the accepting edge. An MTHI/MTLO in the `done` cycle overwrites the matching register one edge later.
- **Outputs:** `hi`/`lo` are registered and hold between operations. `busy` and `done` are registered, with no combinational path from inputs.

## Configuration
- **`MDU_DIV_EN` defined:** full behaviour above.
- **`MDU_DIV_EN` undefined:**
  - The divide datapath and divide-by-zero logic are not compiled.
  - Op codes 010 and 011 behave as reserved: ignored, `busy` stays 0, no `done`, HI/LO unchanged.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan
- **Reset:** assert `reset` 2 cycles after random activity → `hi`=0, `lo`=0, `busy`=0, `done`=0.
- **Signed and unsigned multiply:**
  - MULT with `sData`=0xFFFFFFFD, `tData`=7 → 33 cycles later `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, and `done` high for exactly one cycle.
  - MULTU with 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed divide and corner cases:**
  - DIV with `sData`=0xFFFFFFF9 (−7), `tData`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIVU with `sData`=7, `tData`=0 → after 33 cycles `lo`=0xFFFFFFFF, `hi`=7, and `done` pulses.
- **Busy and abort:**
  - MULT started, then MTHI 0xAAAA5555 while `busy`=1 → MTHI ignored, and `hi` holds the product after `done`.
  - Assert `reset` at cycle 10 of a DIV → `busy`=0, `hi`=`lo`=0 next cycle, and no `done`.
- **Moves and back-to-back:**
  - MTLO with 0x12345678 → `lo`=0x12345678 next cycle, `busy` stays 0, no `done`.
  - MULTU 3×5 issued in the `done` cycle of a prior op → accepted with no dead cycle, giving `lo`=15.
  - With `MDU_DIV_EN` undefined, DIV → no `busy`, no `done`, HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply and restoring divide into HI/LO.
// Define MDU_DIV_EN to compile the divide datapath (DIV/DIVU).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] sData,
  input  logic [WIDTH-1:0] tData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_mul, op_mthi, op_mtlo;
  logic             sgn, s_neg, t_neg;
  logic [WIDTH-1:0] s_mag, t_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    p_mul, p_fix;

`ifdef MDU_DIV_EN
  logic             div_q, div_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] sv_q, sv_d;
  logic             op_div;
  logic [WIDTH:0]   div_sh, div_df;
  logic [W2-1:0]    p_div;
  logic [WIDTH-1:0] quo, rem;
`endif

  assign op_mul  = (op[2:1] == 2'b00);
  assign op_mthi = (op == 3'b100);
  assign op_mtlo = (op == 3'b101);
  assign sgn     = ~op[0];
  assign s_neg   = sgn & sData[WIDTH-1];
  assign t_neg   = sgn & tData[WIDTH-1];
  assign s_mag   = s_neg ? -sData : sData;
  assign t_mag   = t_neg ? -tData : tData;

  assign mul_sum = {1'b0, p_q[W2-1:WIDTH]}
                 + {1'b0, (p_q[0] ? b_q : {WIDTH{1'b0}})};
  assign p_mul   = {mul_sum, p_q[WIDTH-1:1]};
  assign p_fix   = neg_q ? -p_q : p_q;

`ifdef MDU_DIV_EN
  assign op_div = (op[2:1] == 2'b01);
  assign div_sh = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
  assign div_df = div_sh - {1'b0, b_q};
  assign p_div  = {(div_df[WIDTH] ? div_sh[WIDTH-1:0]
                                  : div_df[WIDTH-1:0]),
                   p_q[WIDTH-2:0], ~div_df[WIDTH]};
  assign quo    = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem    = rneg_q ? -p_q[W2-1:WIDTH] : p_q[W2-1:WIDTH];
`endif

  // Next-state and datapath update for accept, iterate and commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    b_d     = b_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    sv_d    = sv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            op_mul: begin
              state_d = ITER;
              cnt_d   = '0;
              p_d     = {{WIDTH{1'b0}}, t_mag};
              b_d     = s_mag;
              neg_d   = s_neg ^ t_neg;
`ifdef MDU_DIV_EN
              div_d   = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            op_div: begin
              state_d = ITER;
              cnt_d   = '0;
              p_d     = {{WIDTH{1'b0}}, s_mag};
              b_d     = t_mag;
              neg_d   = s_neg ^ t_neg;
              div_d   = 1'b1;
              rneg_d  = s_neg;
              dz_d    = (tData == '0);
              sv_d    = sData;
            end
`endif
            op_mthi: hi_d = sData;
            op_mtlo: lo_d = sData;
            default: ;
          endcase
        end
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
`ifdef MDU_DIV_EN
        p_d   = div_q ? p_div : p_mul;
`else
        p_d   = p_mul;
`endif
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d      = IDLE;
        done_d       = 1'b1;
        {hi_d, lo_d} = p_fix;
`ifdef MDU_DIV_EN
        if (div_q) begin
          hi_d = dz_q ? sv_q : rem;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      p_q    <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      sv_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      b_q    <= b_d;
      neg_q  <= neg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
`ifdef MDU_DIV_EN
      div_q  <= div_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      sv_q   <= sv_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table plus scoreboard for mult_div_unit.
// Divide vectors are exercised only when MDU_DIV_EN is defined.
module tb_mult_div_unit;
  localparam int W = 32;
  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] sData, tData, hi, lo;
  logic         busy, done;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .sData(sData), .tData(tData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] s, t, eh, el;
  } vec_t;

  vec_t         vt[$];
  logic [63:0]  sb[$];
  logic [W-1:0] m_hi, m_lo;
  int           acc_cyc;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic void add(input logic [2:0] o, input logic [W-1:0] s,
                              input logic [W-1:0] t, input logic [W-1:0] eh,
                              input logic [W-1:0] el);
    vec_t v;
    v.op = o; v.s = s; v.t = t; v.eh = eh; v.el = el;
    vt.push_back(v);
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] s,
                       input logic [W-1:0] t);
    op = o; sData = s; tData = t; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    sData = $urandom;
    tData = $urandom;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    bit bdrop = 0;
    logic [63:0] e;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) bdrop = 1;
    end
    chk({nm, " done seen"}, 64'(seen), 64'd1);
    chk({nm, " busy held"}, 64'(bdrop), 64'd0);
    if (seen) begin
      chk({nm, " latency"}, 64'(cyc - acc_cyc), 64'(W + 1));
      chk({nm, " busy low"}, 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard: got empty expected entry", nm);
      end else begin
        e = sb.pop_front();
        chk({nm, " hi"}, 64'(hi), 64'(e[63:32]));
        chk({nm, " lo"}, 64'(lo), 64'(e[31:0]));
      end
    end
  endtask

  task automatic no_done(input int n, input string nm);
    bit s = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) s = 1;
    end
    chk(nm, 64'(s), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; sData = '0; tData = '0;
    m_hi = '0; m_lo = '0;

    add(MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    add(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    add(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    add(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    add(MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
    add(MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    add(MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);
`ifdef MDU_DIV_EN
    add(DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add(DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    add(DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    add(DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    add(DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF);
    add(DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
`endif

    repeat (2) @(negedge clk);
    chk("por hi", 64'(hi), 64'd0);
    chk("por lo", 64'(lo), 64'd0);
    chk("por busy", 64'(busy), 64'd0);
    chk("por done", 64'(done), 64'd0);
    reset = 1'b0;

    issue(MTHI, $urandom | 32'h1, '0);
    issue(MTLO, $urandom | 32'h1, '0);
    issue(MULT, $urandom, $urandom);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    op = MTHI; sData = 32'hFFFF0000; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    no_done(W + 5, "rst no done");

    foreach (vt[i]) begin
      sb.push_back({vt[i].eh, vt[i].el});
      issue(vt[i].op, vt[i].s, vt[i].t);
      wait_done($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i), 64'(done), 64'd0);
      m_hi = vt[i].eh;
      m_lo = vt[i].el;
    end

    sb.push_back({32'h1, 32'h0});
    issue(MULT, 32'h00010000, 32'h00010000);
    repeat (4) @(negedge clk);
    op = MTHI; sData = 32'hAAAA5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mthi busy hi", 64'(hi), 64'(m_hi));
    wait_done("mult+mthi");
    m_hi = 32'h1; m_lo = 32'h0;

    sb.push_back({32'h0, 32'd42});
    issue(MULTU, 32'd6, 32'd7);
    wait_done("b2b first");
    sb.push_back({32'h0, 32'd15});
    issue(MULTU, 32'd3, 32'd5);
    chk("b2b accept busy", 64'(busy), 64'd1);
    wait_done("b2b second");
    issue(MTHI, 32'h5A5A0F0F, '0);
    chk("mthi done hi", 64'(hi), 64'h5A5A0F0F);
    chk("mthi done lo", 64'(lo), 64'd15);
    m_hi = 32'h5A5A0F0F; m_lo = 32'd15;

    issue(MTLO, 32'h12345678, '0);
    chk("mtlo lo", 64'(lo), 64'h12345678);
    chk("mtlo hi", 64'(hi), 64'(m_hi));
    chk("mtlo busy", 64'(busy), 64'd0);
    no_done(5, "mtlo no done");
    m_lo = 32'h12345678;

    issue(3'b110, 32'hDEADBEEF, 32'h1);
    chk("rsv busy", 64'(busy), 64'd0);
    no_done(W + 3, "rsv no done");
    chk("rsv hi", 64'(hi), 64'(m_hi));
    chk("rsv lo", 64'(lo), 64'(m_lo));

`ifndef MDU_DIV_EN
    issue(DIV, 32'd100, 32'd7);
    chk("nodiv busy", 64'(busy), 64'd0);
    no_done(W + 3, "nodiv no done");
    issue(DIVU, 32'd100, 32'd0);
    chk("nodivu busy", 64'(busy), 64'd0);
    no_done(W + 3, "nodivu no done");
    chk("nodiv hi", 64'(hi), 64'(m_hi));
    chk("nodiv lo", 64'(lo), 64'(m_lo));
`endif

`ifdef MDU_DIV_EN
    issue(DIV, 32'd7, 32'd3);
`else
    issue(MULT, 32'd7, 32'd3);
`endif
    repeat (9) @(negedge clk);
    chk("abort busy pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    no_done(W + 5, "abort no done");

    chk("sb drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
